// File: rtl/bp_nonsynth_cache_profiler_if.sv
// Snapshot readout port of the cache profiler: valid/yumi handshake with a
// channel-selected view of the snapshot bank.
interface bp_nonsynth_cache_profiler_if #(
    parameter int num_caches_p    = 2,
    parameter int counter_width_p = 32,
    parameter int lg_caches_lp    = (num_caches_p > 1) ? $clog2(num_caches_p) : 1
);
    logic                         snap_v_o;
    logic                         snap_yumi_i;
    logic [lg_caches_lp-1:0]      snap_sel_i;
    logic [6*counter_width_p-1:0] snap_data_o;
    logic [counter_width_p-1:0]   snap_window_o;

    modport master (
        output snap_v_o, snap_data_o, snap_window_o,
        input  snap_yumi_i, snap_sel_i
    );

    modport slave (
        input  snap_v_o, snap_data_o, snap_window_o,
        output snap_yumi_i, snap_sel_i
    );
endinterface

// File: rtl/bp_nonsynth_cache_profiler.sv
// Windowed per-cache hit/miss and miss-latency profiler with a snapshot bank
// that is handed to a consumer through a valid/yumi handshake.
module bp_nonsynth_cache_profiler #(
    parameter int  num_caches_p    = 2,
    parameter int  counter_width_p = 32,
    parameter int  window_cycles_p = 1024,
    localparam int lg_caches_lp    = (num_caches_p > 1) ? $clog2(num_caches_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       freeze_i,
    input  logic [num_caches_p-1:0]    load_hit_i,
    input  logic [num_caches_p-1:0]    load_miss_i,
    input  logic [num_caches_p-1:0]    store_hit_i,
    input  logic [num_caches_p-1:0]    store_miss_i,
    input  logic [num_caches_p-1:0]    req_v_i,
    input  logic [num_caches_p-1:0]    req_complete_i,
    output logic [counter_width_p-1:0] dropped_o,
    output logic [num_caches_p-1:0]    req_err_o,
    bp_nonsynth_cache_profiler_if.master snap
);
    localparam int cw_lp = counter_width_p;
    localparam int wt_w_lp = $clog2(window_cycles_p);

    typedef logic [cw_lp-1:0] cnt_t;

    typedef struct packed {
        cnt_t max_lat;
        cnt_t lat_sum;
        cnt_t store_miss;
        cnt_t store_hit;
        cnt_t load_miss;
        cnt_t load_hit;
    } stats_s;

    typedef enum logic {e_idle, e_busy} lat_state_e;

    function automatic cnt_t sat_inc(cnt_t a);
        return (&a) ? a : a + cnt_t'(1);
    endfunction

    function automatic cnt_t sat_add(cnt_t a, cnt_t b);
        logic [cw_lp:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[cw_lp] ? '1 : s[cw_lp-1:0];
    endfunction

    lat_state_e state_q [num_caches_p];
    lat_state_e state_n [num_caches_p];
    cnt_t       timer_q [num_caches_p];
    cnt_t       timer_n [num_caches_p];
    logic       rec_v   [num_caches_p];
    cnt_t       rec_lat [num_caches_p];
    logic [num_caches_p-1:0] err_set;

    stats_s live_q   [num_caches_p];
    stats_s live_upd [num_caches_p];
    stats_s bank_q   [num_caches_p];

    logic [wt_w_lp-1:0]      win_timer_q;
    cnt_t                    win_idx_q;
    cnt_t                    snap_win_q;
    cnt_t                    dropped_q;
    logic                    snap_v_q;
    logic [num_caches_p-1:0] req_err_q;
    logic                    boundary;
    logic                    bank_free;
    logic [lg_caches_lp-1:0] sel;

    // Latency FSM next-state logic, one instance per channel.
    always_comb begin
        for (int c = 0; c < num_caches_p; c++) begin
            // NOTE: every output gets a default first so no path can infer a latch.
            state_n[c] = state_q[c];
            timer_n[c] = timer_q[c];
            rec_v[c]   = 1'b0;
            rec_lat[c] = '0;
            err_set[c] = 1'b0;
            if (!freeze_i) begin
                unique case (state_q[c])
                    e_idle: begin
                        if (req_complete_i[c]) begin
                            if (req_v_i[c]) rec_v[c] = 1'b1;
                            else            err_set[c] = 1'b1;
                        end else if (req_v_i[c]) begin
                            state_n[c] = e_busy;
                            timer_n[c] = '0;
                        end
                    end
                    e_busy: begin
                        timer_n[c] = sat_inc(timer_q[c]);
                        if (req_complete_i[c]) begin
                            rec_v[c]   = 1'b1;
                            rec_lat[c] = sat_inc(timer_q[c]);
                            if (req_v_i[c]) timer_n[c] = '0;
                            else            state_n[c] = e_idle;
                        end else if (req_v_i[c]) begin
                            err_set[c] = 1'b1;
                        end
                    end
                    default: state_n[c] = e_idle;
                endcase
            end
        end
    end

    // Live counters including this cycle's events, so a boundary snapshot
    // captures events that land in the boundary cycle itself.
    always_comb begin
        for (int c = 0; c < num_caches_p; c++) begin
            live_upd[c] = live_q[c];
            if (!freeze_i) begin
                if (load_hit_i[c])   live_upd[c].load_hit   = sat_inc(live_q[c].load_hit);
                if (load_miss_i[c])  live_upd[c].load_miss  = sat_inc(live_q[c].load_miss);
                if (store_hit_i[c])  live_upd[c].store_hit  = sat_inc(live_q[c].store_hit);
                if (store_miss_i[c]) live_upd[c].store_miss = sat_inc(live_q[c].store_miss);
                if (rec_v[c]) begin
                    live_upd[c].lat_sum = sat_add(live_q[c].lat_sum, rec_lat[c]);
                    if (rec_lat[c] > live_q[c].max_lat) live_upd[c].max_lat = rec_lat[c];
                end
            end
        end
    end

    assign boundary  = !freeze_i && (win_timer_q == wt_w_lp'(window_cycles_p - 1));
    assign bank_free = !snap_v_q || snap.snap_yumi_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int c = 0; c < num_caches_p; c++) begin
                state_q[c] <= e_idle;
                timer_q[c] <= '0;
                live_q[c]  <= '0;
                // NOTE: the bank is plain flops, cleared so readout after reset is defined.
                bank_q[c]  <= '0;
            end
            win_timer_q <= '0;
            win_idx_q   <= '0;
            snap_win_q  <= '0;
            dropped_q   <= '0;
            snap_v_q    <= 1'b0;
            req_err_q   <= '0;
        end else begin
            for (int c = 0; c < num_caches_p; c++) begin
                state_q[c] <= state_n[c];
                timer_q[c] <= timer_n[c];
                live_q[c]  <= boundary ? '0 : live_upd[c];
            end
            req_err_q <= req_err_q | err_set;
            if (!freeze_i) win_timer_q <= boundary ? '0 : win_timer_q + wt_w_lp'(1);
            if (boundary) begin
                win_idx_q <= sat_inc(win_idx_q);
                if (bank_free) begin
                    bank_q     <= live_upd;
                    snap_win_q <= win_idx_q;
                    snap_v_q   <= 1'b1;
                end else begin
                    dropped_q <= sat_inc(dropped_q);
                end
            end else if (snap.snap_yumi_i) begin
                snap_v_q <= 1'b0;
            end
        end
    end

    assign sel = snap.snap_sel_i;

    always_comb begin
        snap.snap_data_o = '0;
        if (int'(sel) < num_caches_p) snap.snap_data_o = bank_q[sel];
    end

    assign snap.snap_v_o      = snap_v_q;
    assign snap.snap_window_o = snap_win_q;
    assign dropped_o          = dropped_q;
    assign req_err_o          = req_err_q;
endmodule

// File: tb/tb_bp_nonsynth_cache_profiler.sv
// Bench for the cache profiler: two instances (wide counters / narrow saturating
// counters with a non-power-of-two channel count) against a tick-based reference model.
module tb_bp_nonsynth_cache_profiler;
    localparam int W   = 16;
    localparam int NM  = 3;
    localparam int NA  = 2;
    localparam int CWA = 32;
    localparam int NB  = 3;
    localparam int CWB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, frz, yumi;
    logic [NM-1:0] lh, lm, sh, sm, rv, rc;
    logic [0:0]    sel_a;
    logic [1:0]    sel_b;
    logic [CWA-1:0] drop_a;
    logic [CWB-1:0] drop_b;
    logic [NA-1:0]  err_a;
    logic [NB-1:0]  err_b;

    bp_nonsynth_cache_profiler_if #(.num_caches_p(NA), .counter_width_p(CWA)) ia ();
    bp_nonsynth_cache_profiler_if #(.num_caches_p(NB), .counter_width_p(CWB)) ib ();

    assign ia.snap_yumi_i = yumi;
    assign ia.snap_sel_i  = sel_a;
    assign ib.snap_yumi_i = yumi;
    assign ib.snap_sel_i  = sel_b;

    bp_nonsynth_cache_profiler #(.num_caches_p(NA), .counter_width_p(CWA), .window_cycles_p(W)) dut_a (
        .clk_i(clk), .reset_i(rst), .freeze_i(frz),
        .load_hit_i(lh[NA-1:0]), .load_miss_i(lm[NA-1:0]),
        .store_hit_i(sh[NA-1:0]), .store_miss_i(sm[NA-1:0]),
        .req_v_i(rv[NA-1:0]), .req_complete_i(rc[NA-1:0]),
        .dropped_o(drop_a), .req_err_o(err_a), .snap(ia.master)
    );

    bp_nonsynth_cache_profiler #(.num_caches_p(NB), .counter_width_p(CWB), .window_cycles_p(W)) dut_b (
        .clk_i(clk), .reset_i(rst), .freeze_i(frz),
        .load_hit_i(lh), .load_miss_i(lm), .store_hit_i(sh), .store_miss_i(sm),
        .req_v_i(rv), .req_complete_i(rc),
        .dropped_o(drop_b), .req_err_o(err_b), .snap(ib.master)
    );

    // Reference model: true (unbounded) statistics, clamped only when compared.
    // Field order 0..5: load_hit, load_miss, store_hit, store_miss, lat_sum, max_lat.
    longint    m_cnt  [NM][6];
    longint    m_bank [NM][6];
    bit        m_v;
    longint    m_bwin, m_drop, m_tick;
    bit        m_busy [NM];
    longint    m_open [NM];
    bit [NM-1:0] m_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint clampv(longint v, int cw);
        longint mx;
        mx = (longint'(1) << cw) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [255:0] exp_data(int ch, int n, int cw);
        logic [255:0] r;
        r = '0;
        if (ch < n)
            for (int k = 0; k < 6; k++)
                r = r | (256'(clampv(m_bank[ch][k], cw)) << (k * cw));
        return r;
    endfunction

    function automatic void record(int c, longint lat);
        m_cnt[c][4] += lat;
        if (lat > m_cnt[c][5]) m_cnt[c][5] = lat;
    endfunction

    function automatic void model_update();
        bit bnd;
        if (rst) begin
            for (int c = 0; c < NM; c++) begin
                for (int k = 0; k < 6; k++) begin
                    m_cnt[c][k]  = 0;
                    m_bank[c][k] = 0;
                end
                m_busy[c] = 0;
                m_open[c] = 0;
            end
            m_v = 0; m_bwin = 0; m_drop = 0; m_tick = 0; m_err = '0;
            return;
        end
        if (frz) begin
            if (yumi) m_v = 0;
            return;
        end
        for (int c = 0; c < NM; c++) begin
            m_cnt[c][0] += longint'(lh[c]);
            m_cnt[c][1] += longint'(lm[c]);
            m_cnt[c][2] += longint'(sh[c]);
            m_cnt[c][3] += longint'(sm[c]);
            if (rc[c]) begin
                if (m_busy[c]) begin
                    record(c, m_tick - m_open[c]);
                    if (rv[c]) m_open[c] = m_tick;
                    else       m_busy[c] = 0;
                end else if (rv[c]) record(c, 0);
                else                m_err[c] = 1'b1;
            end else if (rv[c]) begin
                if (m_busy[c]) m_err[c] = 1'b1;
                else begin
                    m_busy[c] = 1;
                    m_open[c] = m_tick;
                end
            end
        end
        bnd = (m_tick % W) == W - 1;
        if (bnd) begin
            if (!m_v || yumi) begin
                m_bank = m_cnt;
                m_bwin = m_tick / W;
                m_v    = 1;
            end else begin
                m_drop++;
            end
            for (int c = 0; c < NM; c++)
                for (int k = 0; k < 6; k++) m_cnt[c][k] = 0;
        end else if (yumi) begin
            m_v = 0;
        end
        m_tick++;
    endfunction

    task automatic check_all();
        check("snap_v_a",   ia.snap_v_o, m_v);
        check("snap_v_b",   ib.snap_v_o, m_v);
        check("window_a",   ia.snap_window_o, clampv(m_bwin, CWA));
        check("window_b",   ib.snap_window_o, clampv(m_bwin, CWB));
        check("dropped_a",  drop_a, clampv(m_drop, CWA));
        check("dropped_b",  drop_b, clampv(m_drop, CWB));
        check("req_err_a",  err_a, m_err[NA-1:0]);
        check("req_err_b",  err_b, m_err);
        check("snap_data_a", ia.snap_data_o, exp_data(int'(sel_a), NA, CWA));
        check("snap_data_b", ib.snap_data_o, exp_data(int'(sel_b), NB, CWB));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic quiet();
        lh = '0; lm = '0; sh = '0; sm = '0; rv = '0; rc = '0;
        frz = 1'b0; yumi = 1'b0; rst = 1'b0;
    endtask

    task automatic field_a(input int ch, input int k, output logic [CWA-1:0] v);
        sel_a = ch[0:0];
        #1;
        v = ia.snap_data_o[k*CWA +: CWA];
    endtask

    logic [CWA-1:0] f;
    int             wall;

    initial begin
        quiet();
        sel_a = '0;
        sel_b = '0;
        rst   = 1'b1;
        @(negedge clk);
        step();
        step();
        check("reset_snap_v", ia.snap_v_o, 1'b0);
        rst = 1'b0;

        // Window 0: event counts and two back-to-back latency measurements.
        for (int t = 0; t < 16; t++) begin
            quiet();
            lh[0] = (t < 5);
            sm[1] = (t < 3);
            rv[0] = (t == 2) || (t == 10);
            rc[0] = (t == 9) || (t == 12);
            step();
        end
        quiet();
        check("w0_snap_v", ia.snap_v_o, 1'b1);
        check("w0_window", ia.snap_window_o, 0);
        field_a(0, 0, f); check("w0_load_hit_ch0", f, 5);
        field_a(1, 3, f); check("w0_store_miss_ch1", f, 3);
        field_a(0, 4, f); check("w0_lat_sum_ch0", f, 9);
        field_a(0, 5, f); check("w0_max_lat_ch0", f, 7);
        check("w0_req_err", err_a, 2'b00);

        // Windows 1 and 2 with no yumi: both are dropped; idle completion flags ch1.
        for (int t = 16; t < 48; t++) begin
            quiet();
            rc[1] = (t == 17);
            lh[1] = t[0];
            step();
        end
        quiet();
        check("drop_window", ia.snap_window_o, 0);
        check("drop_count", drop_a, 2);
        check("idle_complete_err", err_a, 2'b10);
        yumi = 1'b1;
        step();
        quiet();
        check("yumi_clears_v", ia.snap_v_o, 1'b0);

        // Request across a boundary, then yumi on a boundary cycle.
        for (int t = 49; t < 80; t++) begin
            quiet();
            rv[0] = (t == 62);
            rc[0] = (t == 68);
            rc[1] = (t == 70);
            yumi  = (t == 79);
            if (t == 79) check("pre_bnd_window", ia.snap_window_o, 3);
            step();
        end
        quiet();
        check("bnd_yumi_v", ia.snap_v_o, 1'b1);
        check("bnd_yumi_window", ia.snap_window_o, 4);
        check("bnd_yumi_dropped", drop_a, 2);
        field_a(0, 4, f); check("cross_lat_sum_ch0", f, 6);
        field_a(1, 4, f); check("idle_lat_sum_ch1", f, 0);

        // Freeze for 10 cycles mid-window: events ignored, boundary delayed by 10.
        wall = 0;
        for (int w = 0; w < 60; w++) begin
            quiet();
            yumi  = (w == 0);
            frz   = (w >= 5) && (w < 15);
            lh[0] = (w < 15);
            step();
            wall++;
            if (ia.snap_v_o) break;
        end
        quiet();
        check("freeze_boundary_delay", wall, 26);
        field_a(0, 0, f); check("freeze_load_hit_ch0", f, 5);

        // Randomized traffic, including rare resets and freezes.
        for (int i = 0; i < 3000; i++) begin
            quiet();
            frz   = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 999) == 0);
            lh    = NM'($urandom);
            lm    = NM'($urandom) & NM'($urandom);
            sh    = NM'($urandom);
            sm    = NM'($urandom) & NM'($urandom);
            for (int c = 0; c < NM; c++) begin
                rv[c] = ($urandom_range(0, 5) == 0);
                rc[c] = ($urandom_range(0, 5) == 0);
            end
            yumi  = m_v && ($urandom_range(0, 3) == 0);
            sel_a = 1'($urandom);
            sel_b = 2'($urandom_range(0, 3));
            step();
        end

        // Reset at cycle 5 of a window with a request outstanding.
        quiet();
        for (int i = 0; i < 40 && (m_tick % W) != 4; i++) step();
        rv[0] = 1'b1;
        lh    = '1;
        step();
        quiet();
        rst = 1'b1;
        step();
        quiet();
        check("rst_snap_v", ia.snap_v_o, 1'b0);
        check("rst_window", ia.snap_window_o, 0);
        check("rst_dropped", drop_a, 0);
        check("rst_req_err", err_a, 2'b00);
        field_a(0, 0, f); check("rst_data_ch0", f, 0);
        rc[0] = 1'b1;
        step();
        quiet();
        check("rst_discards_req", err_a, 2'b01);
        for (int i = 0; i < 20; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/bp_nonsynth_cache_profiler.md
Name: bp_nonsynth_cache_profiler

Overview:
- Windowed, multi-channel performance profiler for L1 caches, one channel per cache (I$/D$ per core).
- Counts load/store hits and misses per channel and measures miss-service latency from cache request to completion.
- Snapshots all counters at fixed window boundaries into a readout bank with a valid/yumi handshake.
- Sits beside the caches in the nonsynth test harness. It is the counting successor to the per-event cache tracers: statistics are aggregated per window instead of logged per event.

Parameters:
- num_caches_p, 2, number of monitored cache channels (>=1).
- counter_width_p, 32, width of every event, latency and window counter; all saturate.
- window_cycles_p, 1024, length of one sampling window in unfrozen cycles (>=2).
- lg_caches_lp, BSG_SAFE_CLOG2(num_caches_p), localparam, width of the channel select.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, synchronous, active-high.
- freeze_i  in  1  while high, all counting and timing are suspended.
- load_hit_i  in  num_caches_p  per-channel load hit pulse.
- load_miss_i  in  num_caches_p  per-channel load miss pulse.
- store_hit_i  in  num_caches_p  per-channel store hit pulse.
- store_miss_i  in  num_caches_p  per-channel store miss pulse.
- req_v_i  in  num_caches_p  per-channel cache request issued (opens a latency measurement).
- req_complete_i  in  num_caches_p  per-channel cache request completed (closes the measurement).
- snap_v_o  out  1  snapshot bank holds an unread window.
- snap_yumi_i  in  1  consumer accepts the snapshot; legal only while snap_v_o=1.
- snap_sel_i  in  lg_caches_lp  selects the channel shown on snap_data_o.
- snap_data_o  out  6*counter_width_p  selected channel, packed MSB to LSB as {max_lat, lat_sum, store_miss, store_hit, load_miss, load_hit}.
- snap_window_o  out  counter_width_p  index of the window held in the snapshot (first window = 0).
- dropped_o  out  counter_width_p  count of windows lost because the bank was still full.
- req_err_o  out  num_caches_p  sticky protocol error per channel.

Behaviour:
- Reset values: all live counters, snapshot bank, window timer, window index and dropped_o are 0; snap_v_o=0; req_err_o=0; all channels idle (no outstanding request).
- Event counting:
  - Each cycle with freeze_i=0, every asserted event bit adds 1 to its channel counter.
  - Several events on different bits or channels in the same cycle all count.
  - Counters saturate at all-ones and never wrap.
- Latency FSM, one per channel, states IDLE and BUSY:
  - IDLE, req_v_i=1: go to BUSY, timer=0.
  - BUSY: timer +1 each unfrozen cycle.
  - BUSY, req_complete_i=1: record lat = timer+1. A request at cycle t completed at cycle t+k gives lat=k.
  - Recording a lat does lat_sum += lat (saturating) and max_lat = max(max_lat, lat).
  - BUSY, req_complete_i=1 and req_v_i=1 in the same cycle: close the old request, then open a new one (timer=0, stay BUSY). No error.
  - IDLE, req_v_i=1 and req_complete_i=1 in the same cycle: record lat=0, stay IDLE.
  - IDLE, req_complete_i alone: set req_err_o bit, ignore the completion.
  - BUSY, req_v_i without complete: set req_err_o bit, keep the original timer.
  - req_err_o clears only on reset.
- Window boundary:
  - The window timer counts unfrozen cycles 0..window_cycles_p-1 and wraps.
  - The cycle where it equals window_cycles_p-1 is the boundary cycle.
  - Events in the boundary cycle belong to the closing window.
  - At the end of the boundary cycle, if the bank is free (snap_v_o=0, or snap_yumi_i=1 this cycle), copy all channel counters and the window index into the bank and set snap_v_o=1.
  - Otherwise keep the bank unchanged and increment dropped_o (saturating).
  - In both cases, clear the live counters (including max_lat) and increment the window index.
  - An outstanding BUSY request keeps its timer across the boundary; its latency goes to the window in which it completes.
- Handshake:
  - snap_yumi_i with no boundary drops snap_v_o on the next cycle.
  - snap_yumi_i on a boundary cycle keeps snap_v_o=1 with the new contents; nothing is dropped.
  - snap_data_o is combinational from snap_sel_i and the bank. snap_sel_i >= num_caches_p returns 0.
- Freeze: event, latency and window timers all hold. The snapshot handshake still operates.
- Reset mid-operation: everything returns to reset values next cycle; outstanding requests are discarded.

Test Plan (window_cycles_p=16, num_caches_p=2):
- Pulse load_hit_i[0] 5 times and store_miss_i[1] 3 times in cycles 0-15 -> snap_v_o=1 at cycle 16; sel=0 gives load_hit=5; sel=1 gives store_miss=3; snap_window_o=0.
- req_v_i[0] at cycle 2, req_complete_i[0] at cycle 9; req at 10, complete at 12 -> lat_sum=9, max_lat=7, req_err_o=0.
- Never assert yumi across 3 windows -> bank still holds window 0; dropped_o=2; yumi then snap_v_o=0 next cycle.
- Assert yumi on a boundary cycle -> snap_v_o stays 1, snap_window_o increments, dropped_o unchanged.
- req_complete_i[1] with channel idle -> req_err_o=2'b10 and lat_sum unchanged. Request at cycle 14 completing at cycle 20 -> lat=6 appears in window 1's snapshot.
- freeze_i high for 10 cycles mid-window with events pulsing -> no counts. The boundary arrives 10 cycles later than it would without freeze. Reset at cycle 5 of a window -> all outputs 0.
